// File: rtl/dependency_tracker_id.sv
// Dependency tracker for the ID stage.
// Shadows the destination of the instructions in EX, MEM and WB, flags
// source/destination matches for bypass selection, raises a load-use stall
// and counts the cycles lost to load-use stalls (saturating).
module dependency_tracker_id #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_id_i,
    input  logic [REG_W-1:0] rs1_id_i,
    input  logic [REG_W-1:0] rs2_id_i,
    input  logic             use_rs1_id_i,
    input  logic             use_rs2_id_i,
    input  logic [REG_W-1:0] rd_id_i,
    input  logic             rf_we_id_i,
    input  logic             is_load_id_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             valid_ex_o,
    output logic             valid_mem_o,
    output logic             valid_wb_o,
    output logic             data_produced_ex_o,
    output logic             data_produced_mem_o,
    output logic             data_produced_wb_o,
    output logic             depEX_src_a_o,
    output logic             depEX_src_b_o,
    output logic             depMEM_src_a_o,
    output logic             depMEM_src_b_o,
    output logic             depWB_src_a_o,
    output logic             depWB_src_b_o,
    output logic             stall_id_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shadow entries: valid, destination, write-enable, load flag
    logic             ex_v_reg,  mem_v_reg,  wb_v_reg;
    logic [REG_W-1:0] ex_rd_reg, mem_rd_reg, wb_rd_reg;
    logic             ex_we_reg, mem_we_reg, wb_we_reg;
    logic             ex_ld_reg, mem_ld_reg, wb_ld_reg;
    logic [CNT_W-1:0] lu_cnt_reg;

    logic live_ex, live_mem, live_wb;

    // An entry only matters if it is valid and really writes a non-zero register
    assign live_ex  = ex_v_reg  & ex_we_reg  & (ex_rd_reg  != '0);
    assign live_mem = mem_v_reg & mem_we_reg & (mem_rd_reg != '0);
    assign live_wb  = wb_v_reg  & wb_we_reg  & (wb_rd_reg  != '0);

    assign valid_ex_o  = ex_v_reg;
    assign valid_mem_o = mem_v_reg;
    assign valid_wb_o  = wb_v_reg;

    // A load in EX has no data yet; it becomes bypassable from MEM onwards
    assign data_produced_ex_o  = live_ex & ~ex_ld_reg;
    assign data_produced_mem_o = live_mem;
    assign data_produced_wb_o  = live_wb;

    assign depEX_src_a_o  = live_ex  & use_rs1_id_i & (rs1_id_i == ex_rd_reg);
    assign depEX_src_b_o  = live_ex  & use_rs2_id_i & (rs2_id_i == ex_rd_reg);
    assign depMEM_src_a_o = live_mem & use_rs1_id_i & (rs1_id_i == mem_rd_reg);
    assign depMEM_src_b_o = live_mem & use_rs2_id_i & (rs2_id_i == mem_rd_reg);
    assign depWB_src_a_o  = live_wb  & use_rs1_id_i & (rs1_id_i == wb_rd_reg);
    assign depWB_src_b_o  = live_wb  & use_rs2_id_i & (rs2_id_i == wb_rd_reg);

    // Load-use: consumer in ID needs a load result that is still in EX
    assign stall_id_o = valid_id_i & ~flush_i & live_ex & ex_ld_reg
                      & (depEX_src_a_o | depEX_src_b_o);

    assign lu_stall_cnt_o = lu_cnt_reg;

    // Advance, hold or flush the shadow pipeline
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_v_reg   <= 1'b0;
            ex_rd_reg  <= '0;
            ex_we_reg  <= 1'b0;
            ex_ld_reg  <= 1'b0;
            mem_v_reg  <= 1'b0;
            mem_rd_reg <= '0;
            mem_we_reg <= 1'b0;
            mem_ld_reg <= 1'b0;
            wb_v_reg   <= 1'b0;
            wb_rd_reg  <= '0;
            wb_we_reg  <= 1'b0;
            wb_ld_reg  <= 1'b0;
        end else if (flush_i) begin
            // Flushed EX instruction dies; ID instruction is dropped too
            ex_v_reg <= 1'b0;
            if (!stall_i) begin
                wb_v_reg   <= mem_v_reg;
                wb_rd_reg  <= mem_rd_reg;
                wb_we_reg  <= mem_we_reg;
                wb_ld_reg  <= mem_ld_reg;
                mem_v_reg  <= 1'b0;
                mem_rd_reg <= '0;
                mem_we_reg <= 1'b0;
                mem_ld_reg <= 1'b0;
            end
        end else if (!stall_i) begin
            wb_v_reg   <= mem_v_reg;
            wb_rd_reg  <= mem_rd_reg;
            wb_we_reg  <= mem_we_reg;
            wb_ld_reg  <= mem_ld_reg;
            mem_v_reg  <= ex_v_reg;
            mem_rd_reg <= ex_rd_reg;
            mem_we_reg <= ex_we_reg;
            mem_ld_reg <= ex_ld_reg;
            // A load-use stall turns the ID instruction into a bubble in EX
            ex_v_reg   <= valid_id_i & ~stall_id_o;
            ex_rd_reg  <= rd_id_i;
            ex_we_reg  <= rf_we_id_i;
            ex_ld_reg  <= is_load_id_i;
        end
    end

    // Saturating count of cycles actually lost to load-use stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lu_cnt_reg <= '0;
        end else if (stall_id_o && !stall_i && (lu_cnt_reg != '1)) begin
            lu_cnt_reg <= lu_cnt_reg + CNT_ONE;
        end
    end

endmodule
